// File: rtl/gps_point_feeder.sv
// Point feeder for the GPS distance calculator: FIFO-buffers host points, issues one
// point per DEN when the calculator is idle, and holds each result behind a valid/ready.
module gps_point_feeder #(
  parameter int DEPTH     = 4,
  parameter int FIRST_GAP = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_lon,
  input  logic [23:0] in_lat,
  output logic        DEN,
  output logic [23:0] LON_IN,
  output logic [23:0] LAT_IN,
  input  logic        Valid,
  input  logic [39:0] D,
  input  logic [63:0] a,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [39:0] res_d,
  output logic [63:0] res_a,
  output logic [15:0] res_idx,
  output logic        timeout_err,
  input  logic        clr_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [9:0] GAP_END  = 10'(FIRST_GAP);
  localparam logic [9:0] WAIT_END = 10'(TIMEOUT - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_V, HOLD} state_e;

  state_e      state_q, state_d;
  logic [47:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [47:0] head;
  logic [9:0]  cnt_q, cnt_d;
  logic        primed_q, primed_d;
  logic        den_q, den_d;
  logic [23:0] lon_q, lon_d, lat_q, lat_d;
  logic        res_valid_q, res_valid_d;
  logic [39:0] res_d_q, res_d_d;
  logic [63:0] res_a_q, res_a_d;
  logic [15:0] res_idx_q, res_idx_d;
  logic        err_q, err_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_lon, in_lat};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    den_d       = 1'b0;
    lon_d       = lon_q;
    lat_d       = lat_q;
    res_valid_d = res_valid_q;
    res_d_d     = res_d_q;
    res_a_d     = res_a_q;
    res_idx_d   = res_idx_q;
    err_d       = err_q;
    pop         = 1'b0;
    if (clr_err) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          den_d          = 1'b1;
          {lon_d, lat_d} = head;
          cnt_d          = '0;
          state_d        = primed_q ? WAIT_V : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == GAP_END) begin
          primed_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      WAIT_V: begin
        // A result arriving on the last allowed cycle still beats the timeout.
        if (Valid) begin
          res_d_d     = D;
          res_a_d     = a;
          res_idx_d   = res_idx_q + 16'd1;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (cnt_q == WAIT_END) begin
          err_d    = 1'b1;
          primed_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      den_q       <= 1'b0;
      lon_q       <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_d_q     <= '0;
      res_a_q     <= '0;
      res_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      den_q       <= den_d;
      lon_q       <= lon_d;
      lat_q       <= lat_d;
      res_valid_q <= res_valid_d;
      res_d_q     <= res_d_d;
      res_a_q     <= res_a_d;
      res_idx_q   <= res_idx_d;
      err_q       <= err_d;
    end
  end

  assign DEN         = den_q;
  assign LON_IN      = lon_q;
  assign LAT_IN      = lat_q;
  assign res_valid   = res_valid_q;
  assign res_d       = res_d_q;
  assign res_a       = res_a_q;
  assign res_idx     = res_idx_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gps_point_feeder.sv
// Bench for gps_point_feeder: a scripted calculator model answers DEN pulses, and
// monitors log points and results for comparison against the expected streams.
module tb_gps_point_feeder;
  localparam int DEPTH = 4, FIRST_GAP = 16, TIMEOUT = 1023;

  logic clk = 1'b0, reset_n = 1'b1;
  logic in_valid, in_ready, DEN, Valid, res_valid, res_ready, timeout_err, clr_err, busy;
  logic [23:0] in_lon, in_lat, LON_IN, LAT_IN;
  logic [39:0] D, res_d;
  logic [63:0] a, res_a;
  logic [15:0] res_idx;

  gps_point_feeder #(.DEPTH(DEPTH), .FIRST_GAP(FIRST_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_lon(in_lon), .in_lat(in_lat), .DEN(DEN), .LON_IN(LON_IN), .LAT_IN(LAT_IN),
    .Valid(Valid), .D(D), .a(a), .res_valid(res_valid), .res_ready(res_ready),
    .res_d(res_d), .res_a(res_a), .res_idx(res_idx), .timeout_err(timeout_err),
    .clr_err(clr_err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [23:0] lon; logic [23:0] lat; } den_t;
  typedef struct { logic [23:0] lon; logic [23:0] lat; } pt_t;
  typedef struct { int cyc; logic [39:0] d; logic [63:0] a; logic [15:0] idx; } res_t;
  typedef struct { bit respond; int lat; logic [39:0] d; logic [63:0] a; } plan_t;
  typedef struct { int due; logic [39:0] d; logic [63:0] a; } pend_t;

  den_t  den_log[$];
  pt_t   acc_pts[$];
  res_t  res_log[$];
  plan_t plan_q[$];
  pend_t pend_q[$];
  den_t  m_den;
  pt_t   m_pt;
  res_t  m_res;
  plan_t m_plan;
  pend_t m_pend;
  int cyc = 0, acc_cnt = 0, den_cnt = 0, ready_errs = 0, den_double = 0, res_hi = 0;
  bit den_prev = 0, spur_req = 0;
  logic [39:0] spur_d;
  logic [63:0] spur_a;
  int n_vec = 0, n_err = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Calculator model: answers each DEN according to the scripted plan.
  initial begin
    Valid = 1'b0; D = '0; a = '0;
    forever begin
      @(posedge clk); #1;
      Valid = 1'b0;
      if (spur_req) begin
        Valid = 1'b1; D = spur_d; a = spur_a; spur_req = 0;
      end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        Valid = 1'b1; D = pend_q[0].d; a = pend_q[0].a; pend_q.delete(0);
      end
    end
  end

  // Monitor: logs DEN points, accepted writes (by FIFO occupancy), and result handshakes.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (DEN) begin
        m_den.cyc = cyc; m_den.lon = LON_IN; m_den.lat = LAT_IN;
        den_log.push_back(m_den);
        den_cnt++;
        $display("den   cyc=%0d lon=%06h lat=%06h", cyc, LON_IN, LAT_IN);
        if (plan_q.size() > 0) begin
          m_plan = plan_q.pop_front();
          if (m_plan.respond) begin
            m_pend.due = cyc + m_plan.lat; m_pend.d = m_plan.d; m_pend.a = m_plan.a;
            pend_q.push_back(m_pend);
          end
        end
      end
      if (DEN && den_prev) den_double++;
      den_prev = DEN;
      if (in_ready !== ((acc_cnt - den_cnt) < DEPTH)) ready_errs++;
      if (in_valid && ((acc_cnt - den_cnt) < DEPTH)) begin
        m_pt.lon = in_lon; m_pt.lat = in_lat;
        acc_pts.push_back(m_pt);
        acc_cnt++;
      end
      if (res_valid) res_hi++;
      if (res_valid && res_ready) begin
        m_res.cyc = cyc; m_res.d = res_d; m_res.a = res_a; m_res.idx = res_idx;
        res_log.push_back(m_res);
        $display("res   cyc=%0d idx=%0d d=%010h", cyc, res_idx, res_d);
      end
    end else begin
      den_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bench_clear();
    den_log.delete(); acc_pts.delete(); res_log.delete(); plan_q.delete(); pend_q.delete();
    acc_cnt = 0; den_cnt = 0; ready_errs = 0; den_double = 0; res_hi = 0; spur_req = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; clr_err = 0;
    reset_n = 0;
    bench_clear();
    repeat (3) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic add_plan(input bit respond, input int lat, input logic [39:0] d, input logic [63:0] av);
    plan_t p;
    p.respond = respond; p.lat = lat; p.d = d; p.a = av;
    plan_q.push_back(p);
  endtask

  task automatic test_reset();
    in_valid = 0; clr_err = 0; res_ready = 1;
    reset_n = 0;
    bench_clear();
    #2;
    n_vec++; if (DEN !== 1'b0) begin n_err++; $display("FAIL rst_den got=%0h exp=0", DEN); end
    n_vec++; if (LON_IN !== 24'h0) begin n_err++; $display("FAIL rst_lon got=%0h exp=0", LON_IN); end
    n_vec++; if (LAT_IN !== 24'h0) begin n_err++; $display("FAIL rst_lat got=%0h exp=0", LAT_IN); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got=%0h exp=0", res_valid); end
    n_vec++; if (res_d !== 40'h0) begin n_err++; $display("FAIL rst_res_d got=%0h exp=0", res_d); end
    n_vec++; if (res_a !== 64'h0) begin n_err++; $display("FAIL rst_res_a got=%0h exp=0", res_a); end
    n_vec++; if (res_idx !== 16'h0) begin n_err++; $display("FAIL rst_res_idx got=%0h exp=0", res_idx); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err got=%0h exp=0", timeout_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_basic();
    int t;
    do_reset();
    res_ready = 1;
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(1, 40, 40'h10, 64'h1111);
    add_plan(1, 40, 40'h20, 64'h2222);
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_lon = 24'h780000 + 24'(k * 256); in_lat = 24'h170000 + 24'(k * 256);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 400 && !(den_log.size() == 3 && res_log.size() == 2); i++) tick();
    repeat (60) tick();
    n_vec++; if (den_log.size() !== 3) begin n_err++; $display("FAIL basic_den_count got=%0d exp=3", den_log.size()); end
    n_vec++; if (res_log.size() !== 2) begin n_err++; $display("FAIL basic_res_count got=%0d exp=2", res_log.size()); end
    if (den_log.size() == 3 && res_log.size() == 2) begin
      n_vec++; if (den_log[0].cyc !== t + 2) begin n_err++; $display("FAIL basic_first_latency got=%0d exp=%0d", den_log[0].cyc, t + 2); end
      n_vec++; if (den_log[1].cyc - den_log[0].cyc !== FIRST_GAP + 2) begin n_err++; $display("FAIL basic_prime_gap got=%0d exp=%0d", den_log[1].cyc - den_log[0].cyc, FIRST_GAP + 2); end
      n_vec++; if (res_log[0].cyc !== den_log[1].cyc + 41) begin n_err++; $display("FAIL basic_res_latency got=%0d exp=%0d", res_log[0].cyc, den_log[1].cyc + 41); end
      n_vec++; if (den_log[2].cyc !== den_log[1].cyc + 43) begin n_err++; $display("FAIL basic_next_den got=%0d exp=%0d", den_log[2].cyc, den_log[1].cyc + 43); end
      for (int k = 0; k < 3; k++) begin
        n_vec++; if ({den_log[k].lon, den_log[k].lat} !== {24'h780000 + 24'(k * 256), 24'h170000 + 24'(k * 256)}) begin
          n_err++; $display("FAIL basic_point%0d got=%06h/%06h exp=%06h/%06h", k, den_log[k].lon, den_log[k].lat, 24'h780000 + 24'(k * 256), 24'h170000 + 24'(k * 256)); end
      end
      n_vec++; if (res_log[0].d !== 40'h10 || res_log[0].idx !== 16'd1) begin n_err++; $display("FAIL basic_res0 got=d%0h/i%0d exp=d10/i1", res_log[0].d, res_log[0].idx); end
      n_vec++; if (res_log[1].d !== 40'h20 || res_log[1].idx !== 16'd2 || res_log[1].a !== 64'h2222) begin n_err++; $display("FAIL basic_res1 got=d%0h/i%0d exp=d20/i2", res_log[1].d, res_log[1].idx); end
    end
    n_vec++; if (res_hi !== 2) begin n_err++; $display("FAIL basic_res_valid_cycles got=%0d exp=2", res_hi); end
    n_vec++; if (den_double !== 0) begin n_err++; $display("FAIL basic_den_adjacent got=%0d exp=0", den_double); end
  endtask

  task automatic test_overflow_backpressure();
    int rs, rr, bad;
    logic [39:0] exp_d [DEPTH];
    do_reset();
    res_ready = 0;
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(1, 40, 40'hA1, 64'hA1A1);
    for (int k = 0; k < DEPTH; k++) begin
      exp_d[k] = 40'({$urandom, $urandom});
      add_plan(1, int'($urandom_range(5, 50)), exp_d[k], 64'(k));
    end
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_lon = 24'h100000 + 24'(k); in_lat = 24'h200000 + 24'(k);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 300 && res_valid !== 1'b1; i++) tick();
    n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_result got=%0h exp=1", res_valid); end
    rs = cyc;
    for (int k = 0; k < DEPTH + 2; k++) begin
      in_valid = 1; in_lon = 24'h400000 + 24'(k); in_lat = 24'h500000 + 24'(k);
      n_vec++; if (in_ready !== (k < DEPTH)) begin n_err++; $display("FAIL ovf_in_ready_%0d got=%0h exp=%0h", k, in_ready, (k < DEPTH)); end
      tick();
    end
    in_valid = 0;
    bad = 0;
    while (cyc < rs + 50) begin
      if (res_valid !== 1'b1 || res_d !== 40'hA1 || DEN !== 1'b0) bad++;
      tick();
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bp_stall_stable got=%0d bad cycles exp=0", bad); end
    n_vec++; if (den_log.size() !== 2) begin n_err++; $display("FAIL bp_no_den got=%0d exp=2", den_log.size()); end
    res_ready = 1; rr = cyc;
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_res_valid_drop got=%0h exp=0", res_valid); end
    for (int i = 0; i < 1500 && !(den_log.size() == 2 + DEPTH && res_log.size() == 1 + DEPTH); i++) tick();
    repeat (20) tick();
    n_vec++; if (den_log.size() !== 2 + DEPTH) begin n_err++; $display("FAIL ovf_den_count got=%0d exp=%0d", den_log.size(), 2 + DEPTH); end
    n_vec++; if (res_log.size() !== 1 + DEPTH) begin n_err++; $display("FAIL ovf_res_count got=%0d exp=%0d", res_log.size(), 1 + DEPTH); end
    if (den_log.size() == 2 + DEPTH && res_log.size() == 1 + DEPTH) begin
      n_vec++; if (den_log[2].cyc !== rr + 2) begin n_err++; $display("FAIL bp_den_after_release got=%0d exp=%0d", den_log[2].cyc, rr + 2); end
      for (int k = 0; k < DEPTH; k++) begin
        n_vec++; if (den_log[2 + k].lon !== 24'h400000 + 24'(k) || den_log[2 + k].lat !== 24'h500000 + 24'(k)) begin
          n_err++; $display("FAIL ovf_point%0d got=%06h/%06h exp=%06h/%06h", k, den_log[2 + k].lon, den_log[2 + k].lat, 24'h400000 + 24'(k), 24'h500000 + 24'(k)); end
        n_vec++; if (res_log[1 + k].d !== exp_d[k] || res_log[1 + k].idx !== 16'(2 + k)) begin
          n_err++; $display("FAIL ovf_res%0d got=d%0h/i%0d exp=d%0h/i%0d", k, res_log[1 + k].d, res_log[1 + k].idx, exp_d[k], 2 + k); end
      end
    end
    n_vec++; if (ready_errs !== 0) begin n_err++; $display("FAIL ovf_in_ready_model got=%0d exp=0", ready_errs); end
  endtask

  task automatic test_timeout();
    int dp, bad;
    do_reset();
    res_ready = 1;
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(1, 30, 40'h55, 64'h5555);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_lon = 24'h010000 + 24'(k); in_lat = 24'h020000 + 24'(k);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 100 && den_log.size() < 2; i++) tick();
    n_vec++; if (den_log.size() !== 2) begin n_err++; $display("FAIL to_second_den got=%0d exp=2", den_log.size()); end
    dp = (den_log.size() >= 2) ? den_log[1].cyc : cyc;
    bad = 0;
    while (cyc < dp + TIMEOUT - 1) begin
      if (res_valid !== 1'b0 || timeout_err !== 1'b0) bad++;
      tick();
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL to_early got=%0d bad cycles exp=0", bad); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_before got=%0h exp=0", timeout_err); end
    clr_err = 1;
    tick();
    clr_err = 0;
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_exact_set_wins got=%0h exp=1", timeout_err); end
    in_valid = 1; in_lon = 24'h030000; in_lat = 24'h040000;
    tick();
    in_valid = 0;
    for (int i = 0; i < 200 && !(den_log.size() == 4 && res_log.size() == 1); i++) tick();
    n_vec++; if (den_log.size() !== 4 || res_log.size() !== 1) begin n_err++; $display("FAIL to_reprime_counts got=%0d/%0d exp=4/1", den_log.size(), res_log.size()); end
    if (den_log.size() == 4 && res_log.size() == 1) begin
      n_vec++; if (den_log[2].cyc !== dp + TIMEOUT + 1) begin n_err++; $display("FAIL to_next_den got=%0d exp=%0d", den_log[2].cyc, dp + TIMEOUT + 1); end
      n_vec++; if (den_log[3].cyc - den_log[2].cyc !== FIRST_GAP + 2) begin n_err++; $display("FAIL to_reprime_gap got=%0d exp=%0d", den_log[3].cyc - den_log[2].cyc, FIRST_GAP + 2); end
      n_vec++; if (res_log[0].d !== 40'h55 || res_log[0].idx !== 16'd1) begin n_err++; $display("FAIL to_result got=d%0h/i%0d exp=d55/i1", res_log[0].d, res_log[0].idx); end
    end
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%0h exp=1", timeout_err); end
    clr_err = 1;
    tick();
    clr_err = 0;
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear got=%0h exp=0", timeout_err); end
  endtask

  task automatic test_spurious();
    int bad;
    repeat (5) tick();
    spur_d = 40'hDEADBEEF01; spur_a = 64'hCAFE;
    spur_req = 1;
    bad = 0;
    repeat (6) begin
      tick();
      if (res_valid !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL spur_res_valid got=%0d bad cycles exp=0", bad); end
    n_vec++; if (res_idx !== 16'd1) begin n_err++; $display("FAIL spur_idx got=%0d exp=1", res_idx); end
    n_vec++; if (res_d !== 40'h55) begin n_err++; $display("FAIL spur_res_d got=%0h exp=55", res_d); end
    n_vec++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL spur_err_busy got=%0h/%0h exp=0/0", timeout_err, busy); end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    res_ready = 1;
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(1, 20, 40'h77, 64'h7777);
    add_plan(0, 0, 40'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_lon = 24'h0A0000 + 24'(k + 1); in_lat = 24'h0B0000 + 24'(k + 1);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 300 && !(den_log.size() == 3 && res_log.size() == 1); i++) tick();
    n_vec++; if (den_log.size() !== 3 || res_log.size() !== 1) begin n_err++; $display("FAIL mid_setup got=%0d/%0d exp=3/1", den_log.size(), res_log.size()); end
    repeat (10) tick();
    #2;
    reset_n = 0;
    bench_clear();
    #1;
    n_vec++; if (DEN !== 1'b0 || LON_IN !== 24'h0 || LAT_IN !== 24'h0) begin n_err++; $display("FAIL mid_point_out got=%0h/%0h/%0h exp=0/0/0", DEN, LON_IN, LAT_IN); end
    n_vec++; if (res_valid !== 1'b0 || res_d !== 40'h0 || res_a !== 64'h0) begin n_err++; $display("FAIL mid_res_out got=%0h/%0h/%0h exp=0/0/0", res_valid, res_d, res_a); end
    n_vec++; if (res_idx !== 16'h0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL mid_idx_err got=%0h/%0h exp=0/0", res_idx, timeout_err); end
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_busy_ready got=%0h/%0h exp=0/1", busy, in_ready); end
    repeat (2) tick();
    reset_n = 1;
    tick();
    add_plan(0, 0, 40'h0, 64'h0);
    add_plan(1, 25, 40'h99, 64'h9999);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_lon = 24'h0C0000 + 24'(k); in_lat = 24'h0D0000 + 24'(k);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 200 && !(den_log.size() == 2 && res_log.size() == 1); i++) tick();
    n_vec++; if (den_log.size() !== 2 || res_log.size() !== 1) begin n_err++; $display("FAIL mid_after_counts got=%0d/%0d exp=2/1", den_log.size(), res_log.size()); end
    if (den_log.size() == 2 && res_log.size() == 1) begin
      n_vec++; if (den_log[1].cyc - den_log[0].cyc !== FIRST_GAP + 2) begin n_err++; $display("FAIL mid_reprime_gap got=%0d exp=%0d", den_log[1].cyc - den_log[0].cyc, FIRST_GAP + 2); end
      n_vec++; if (res_log[0].d !== 40'h99 || res_log[0].idx !== 16'd1) begin n_err++; $display("FAIL mid_result got=d%0h/i%0d exp=d99/i1", res_log[0].d, res_log[0].idx); end
    end
  endtask

  task automatic test_random();
    localparam int N = 12;
    logic [39:0] exp_d [N];
    logic [63:0] exp_a [N];
    do_reset();
    add_plan(0, 0, 40'h0, 64'h0);
    for (int k = 1; k < N; k++) begin
      exp_d[k] = 40'({$urandom, $urandom});
      exp_a[k] = {$urandom, $urandom};
      add_plan(1, int'($urandom_range(1, 60)), exp_d[k], exp_a[k]);
    end
    for (int i = 0; i < 4000 && !(acc_cnt == N && res_log.size() == N - 1); i++) begin
      in_valid = (acc_cnt < N) && ($urandom_range(0, 2) == 0);
      in_lon = 24'($urandom); in_lat = 24'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; res_ready = 1;
    repeat (5) tick();
    n_vec++; if (den_log.size() !== N) begin n_err++; $display("FAIL rnd_den_count got=%0d exp=%0d", den_log.size(), N); end
    n_vec++; if (res_log.size() !== N - 1) begin n_err++; $display("FAIL rnd_res_count got=%0d exp=%0d", res_log.size(), N - 1); end
    if (den_log.size() == N && acc_pts.size() == N && res_log.size() == N - 1) begin
      for (int k = 0; k < N; k++) begin
        n_vec++; if (den_log[k].lon !== acc_pts[k].lon || den_log[k].lat !== acc_pts[k].lat) begin
          n_err++; $display("FAIL rnd_point%0d got=%06h/%06h exp=%06h/%06h", k, den_log[k].lon, den_log[k].lat, acc_pts[k].lon, acc_pts[k].lat); end
      end
      for (int k = 1; k < N; k++) begin
        n_vec++; if (res_log[k - 1].d !== exp_d[k] || res_log[k - 1].a !== exp_a[k] || res_log[k - 1].idx !== 16'(k)) begin
          n_err++; $display("FAIL rnd_res%0d got=d%0h/i%0d exp=d%0h/i%0d", k, res_log[k - 1].d, res_log[k - 1].idx, exp_d[k], k); end
      end
    end
    n_vec++; if (ready_errs !== 0) begin n_err++; $display("FAIL rnd_in_ready_model got=%0d exp=0", ready_errs); end
    n_vec++; if (den_double !== 0) begin n_err++; $display("FAIL rnd_den_adjacent got=%0d exp=0", den_double); end
  endtask

  initial begin
    in_valid = 0; in_lon = '0; in_lat = '0; res_ready = 1; clr_err = 0;
    spur_d = '0; spur_a = '0;
    tick();
    test_reset();
    test_basic();
    test_overflow_backpressure();
    test_timeout();
    test_spurious();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gps_point_feeder.md
# gps_point_feeder

Streaming front end for the GPS distance calculator. Buffers host-written (longitude, latitude) points in a small FIFO and drives the calculator's DEN/LON_IN/LAT_IN input port, one point per DEN pulse. It issues a new point only when the calculator is idle, then captures each Valid/D/a result into a held output register with a valid/ready handshake. It is the transmitting end of the calculator's point-input interface and the receiving end of its result interface.

## Interface
- DEPTH, 4: input FIFO entries (power of 2, ≥2); each entry is {lon[23:0], lat[23:0]}.
- FIRST_GAP, 16: wait cycles after the first (priming) point, which produces no result.
- TIMEOUT, 1023: max cycles spent waiting for Valid (10-bit counter).
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host point write strobe.
- in_ready  out  1  =!fifo_full (combinational).
- in_lon  in  24  longitude, unsigned 8.16 degrees.
- in_lat  in  24  latitude, unsigned 8.16 degrees.
- DEN  out  1  one-cycle point strobe to calculator (registered).
- LON_IN  out  24  point longitude (registered).
- LAT_IN  out  24  point latitude (registered).
- Valid  in  1  calculator result strobe.
- D  in  40  calculator distance.
- a  in  64  calculator intermediate a.
- res_valid  out  1  result held and available.
- res_ready  in  1  consumer accepts result.
- res_d  out  40  captured D.
- res_a  out  64  captured a.
- res_idx  out  16  pair index of the result (1 = points 0→1), wraps at 2^16.
- timeout_err  out  1  sticky; set on Valid timeout.
- clr_err  in  1  synchronous clear of timeout_err.
- busy  out  1  =(state != IDLE) || fifo non-empty.

## Operation
- FIFO push on in_valid && in_ready; pushes are ignored when full. Pop occurs only in IDLE.
- State IDLE: if the FIFO is non-empty, pop and load LON_IN/LAT_IN, then pulse DEN for exactly 1 cycle. The next state is SETTLE when primed=0, otherwise WAIT_V.
- LON_IN/LAT_IN change only in the cycle DEN rises and are held until the next DEN.
- SETTLE: count FIRST_GAP cycles, set primed=1, then go to IDLE. This is the only point that produces no result.
- WAIT_V: counter increments each cycle.
  - On Valid=1: latch D→res_d and a→res_a, increment res_idx, go to HOLD.
  - If the counter reaches TIMEOUT with no Valid: set timeout_err, clear primed (next point re-primes), go to IDLE, produce no result.
- HOLD: res_valid=1. On res_ready=1, res_valid drops the next cycle and the state goes to IDLE. No DEN is issued while in HOLD (backpressure stalls the calculator feed).
- Valid seen outside WAIT_V is ignored; it causes no capture and no error.
- clr_err and a simultaneous new timeout in the same cycle: set wins.
- Push and pop in the same cycle on a full FIFO: the pop frees a slot, but in_ready was low, so the push is not accepted. Push and pop on an empty FIFO: pop is not possible (IDLE saw empty), so only the push happens.
- Reset at any point, including mid-wait, is asynchronous:
  - Outputs, FIFO pointers, res_idx, primed, counters and timeout_err all go to 0; state goes to IDLE.
  - in_ready=1 after reset.

## Timing
- Reset values: DEN=0, LON_IN=0, LAT_IN=0, res_valid=0, res_d=0, res_a=0, res_idx=0, timeout_err=0, busy=0, in_ready=1.
- Write accepted at edge t into an empty FIFO in IDLE → DEN=1 during cycle t+2 (FIFO count visible at t+1, registered pop/DEN).
- Priming: DEN at cycle p → earliest next DEN at p+FIRST_GAP+2.
- Valid high in cycle v → res_valid=1 from cycle v+1. With res_ready tied high: res_valid lasts 1 cycle, and the next DEN occurs at v+3 if the FIFO is non-empty.
- The timeout fires exactly TIMEOUT cycles after DEN.
- DEN is never high in two consecutive cycles. At most one point is outstanding at the calculator.

## Test plan
- Reset then 3 pushes (lon/lat = 0x78_0000/0x17_0000, 0x78_0100/0x17_0100, 0x78_0200/0x17_0200); model calculator asserts Valid 40 cycles after each non-first DEN with D=0x10, 0x20 → exactly 3 DEN pulses, first→second gap = FIRST_GAP+2; res_d=0x10 then 0x20, res_idx=1 then 2.
- Push DEPTH+2 points back to back with the calculator stalled → in_ready=0 after DEPTH accepts; the 2 extra writes are dropped; DEN count equals DEPTH.
- Hold res_ready=0 for 50 cycles after the first result → res_valid/res_d stay stable and no DEN is issued; raising res_ready → res_valid falls the next cycle, DEN 2 cycles later.
- Suppress Valid after the second point → timeout_err=1 exactly TIMEOUT cycles after DEN, no res_valid; the next point takes the priming path (SETTLE, no result); clr_err clears the flag.
- Spurious Valid pulse in IDLE → no capture and res_idx unchanged.
- reset_n asserted during WAIT_V → all outputs immediately 0; the next push behaves as the first point (primed=0).
